// File: rtl/rbz_texq_pkg.sv
// Shared types and constants for the texture-flash arbiter and its bit sequencer.
package rbz_texq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StDone
    } texq_state_e;

    localparam logic [7:0]  RD_CMD_DEFAULT = 8'h6B;
    localparam int unsigned CMD_BITS       = 8;
    localparam int unsigned DATA_NIBBLES   = 2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Phase counters hold "SCLK cycles remaining minus one".
    function automatic logic [7:0] len_m1(input int unsigned n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/texq_bitseq.sv
// SCLK phase generator, per-phase SCLK down-counter and MSB-first command/address shifter.
module texq_bitseq
    import rbz_texq_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_run,
    input  logic              i_shift,
    input  logic [7:0]        i_next_len,
    output logic              o_sclk,
    output logic              o_bit,
    output logic              o_last
);

    logic              phase_q;
    logic [7:0]        cnt_q;
    logic [WORD_W-1:0] shreg_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            if (i_run) begin
                phase_q <= ~phase_q;
            end else begin
                phase_q <= 1'b0;
            end

            if (i_start) begin
                cnt_q   <= len_m1(CMD_BITS);
                shreg_q <= i_word;
            end else if (i_run && phase_q) begin
                // The edge that ends phase H closes one SCLK cycle.
                cnt_q <= (cnt_q == '0) ? i_next_len : cnt_q - 8'd1;
                if (i_shift) begin
                    shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
                end
            end
        end
    end

    assign o_sclk = phase_q;
    assign o_bit  = shreg_q[WORD_W-1];
    assign o_last = i_run & phase_q & (cnt_q == '0);

endmodule

// File: rtl/texq_arbiter.sv
// Two-port arbiter sequencing quad-output fast reads on the texture SPI flash.
// Define TEXQ_RR_EN for round-robin tie-breaking; otherwise port A has fixed priority.
module texq_arbiter
    import rbz_texq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter logic [7:0]  RD_CMD    = RD_CMD_DEFAULT,
    parameter int unsigned DUMMY_CYC = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_a_req,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic              o_a_ack,
    input  logic              i_b_req,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic              o_b_ack,
    output logic [7:0]        o_rdata,
    output logic              o_busy,
    output logic              o_tex_csb,
    output logic              o_tex_sclk,
    output logic              o_tex_oeb0,
    output logic              o_tex_out0,
    input  logic [3:0]        i_tex_in
);

    localparam int unsigned WORD_W = CMD_BITS + ADDR_W;

    texq_state_e       state_q;
    logic              win_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        nib_q;
    logic [7:0]        rdata_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic              busy_q;
    logic              csb_q;
    logic              oeb0_q;

    logic       grant;
    logic       pick_b;
    logic       run;
    logic       shift;
    logic       last;
    logic       sclk;
    logic [7:0] next_len;

    assign grant = i_enable & (i_a_req | i_b_req);

`ifdef TEXQ_RR_EN
    logic last_win_q;

    // On a tie the port that did not win last time goes next.
    always_comb pick_b = i_b_req & (~i_a_req | (last_win_q == PORT_A));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_win_q <= PORT_B;
        end else if (state_q == StIdle && grant) begin
            last_win_q <= pick_b;
        end
    end
`else
    always_comb pick_b = i_b_req & ~i_a_req;
`endif

    assign run   = (state_q == StCmd) || (state_q == StAddr) ||
                   (state_q == StDummy) || (state_q == StData);
    assign shift = (state_q == StCmd) || (state_q == StAddr);

    always_comb begin
        next_len = '0;
        case (state_q)
            StCmd:   next_len = len_m1(ADDR_W);
            StAddr:  next_len = len_m1(DUMMY_CYC);
            StDummy: next_len = len_m1(DATA_NIBBLES);
            default: next_len = '0;
        endcase
    end

    texq_bitseq #(
        .WORD_W(WORD_W)
    ) u_bitseq (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (state_q == StGrant),
        .i_word    ({RD_CMD, addr_q}),
        .i_run     (run),
        .i_shift   (shift),
        .i_next_len(next_len),
        .o_sclk    (sclk),
        .o_bit     (o_tex_out0),
        .o_last    (last)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            win_q   <= PORT_A;
            addr_q  <= '0;
            nib_q   <= '0;
            rdata_q <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            busy_q  <= 1'b0;
            csb_q   <= 1'b1;
            oeb0_q  <= 1'b1;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q <= StGrant;
                        win_q   <= pick_b;
                        addr_q  <= pick_b ? i_b_addr : i_a_addr;
                        busy_q  <= 1'b1;
                        csb_q   <= 1'b0;
                        oeb0_q  <= 1'b0;
                    end
                end
                StGrant: state_q <= StCmd;
                StCmd: begin
                    if (last) state_q <= StAddr;
                end
                StAddr: begin
                    if (last) begin
                        state_q <= StDummy;
                        oeb0_q  <= 1'b1;
                    end
                end
                StDummy: begin
                    if (last) state_q <= StData;
                end
                StData: begin
                    if (sclk) begin
                        if (last) begin
                            state_q <= StDone;
                            rdata_q <= {nib_q, i_tex_in};
                            csb_q   <= 1'b1;
                            a_ack_q <= (win_q == PORT_A);
                            b_ack_q <= (win_q == PORT_B);
                        end else begin
                            nib_q <= i_tex_in;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_a_ack    = a_ack_q;
    assign o_b_ack    = b_ack_q;
    assign o_rdata    = rdata_q;
    assign o_busy     = busy_q;
    assign o_tex_csb  = csb_q;
    assign o_tex_sclk = sclk;
    assign o_tex_oeb0 = oeb0_q;

endmodule
